// File: rtl/dff_pkg.sv
// Shared constants for the dff lane and the dff3 array wrapper: parameter defaults
// and the RETIME_STATUS encoding.
package dff_pkg;

  localparam int DFF_WIDTH_DEFAULT       = 1;
  localparam int DFF_ARRAY_SIZE1_DEFAULT = 1;
  localparam int DFF_ARRAY_SIZE2_DEFAULT = 1;
  localparam int DFF_PIPE_DEPTH_DEFAULT  = 1;

  // RETIME_ON stages carry no reset so synthesis is free to move them.
  localparam int RETIME_OFF = 0;
  localparam int RETIME_ON  = 1;

endpackage

// File: rtl/dff.sv
// One delay lane: PIPE_DEPTH enabled stages of WIDTH bits, a plain wire when
// PIPE_DEPTH is 0, and reset-free stages when RETIME_STATUS is RETIME_ON.
module dff
  import dff_pkg::*;
#(
  parameter int WIDTH         = DFF_WIDTH_DEFAULT,
  parameter int PIPE_DEPTH    = DFF_PIPE_DEPTH_DEFAULT,
  parameter int RETIME_STATUS = RETIME_OFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  generate
    if (PIPE_DEPTH == 0) begin : g_bypass
      // Control inputs are deliberately dead here; no flops are built.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, reset, en};
      assign out = in;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [PIPE_DEPTH];

      if (RETIME_STATUS == RETIME_ON) begin : g_noreset
        logic unused_reset;
        assign unused_reset = reset;

        always_ff @(posedge clk) begin
          if (en) begin
            stage[0] <= in;
            for (int k = 1; k < PIPE_DEPTH; k++) stage[k] <= stage[k-1];
          end
        end
      end else begin : g_reset
        // Reset wins over en so a stalled pipe can still be flushed.
        always_ff @(posedge clk) begin
          if (reset) begin
            for (int k = 0; k < PIPE_DEPTH; k++) stage[k] <= '0;
          end else if (en) begin
            stage[0] <= in;
            for (int k = 1; k < PIPE_DEPTH; k++) stage[k] <= stage[k-1];
          end
        end
      end

      assign out = stage[PIPE_DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dff3.sv
// Two-dimensional array of independent dff lanes sharing clk/reset/en.
// Optional simulation checks are compiled in with `define DFF3_ASSERT_EN.
module dff3
  import dff_pkg::*;
#(
  parameter int WIDTH         = DFF_WIDTH_DEFAULT,
  parameter int ARRAY_SIZE1   = DFF_ARRAY_SIZE1_DEFAULT,
  parameter int ARRAY_SIZE2   = DFF_ARRAY_SIZE2_DEFAULT,
  parameter int PIPE_DEPTH    = DFF_PIPE_DEPTH_DEFAULT,
  parameter int RETIME_STATUS = RETIME_OFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in  [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0],
  output logic [WIDTH-1:0] out [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0]
);

  generate
    for (genvar i = 0; i < ARRAY_SIZE1; i++) begin : g_row
      for (genvar j = 0; j < ARRAY_SIZE2; j++) begin : g_col
        dff #(
          .WIDTH        (WIDTH),
          .PIPE_DEPTH   (PIPE_DEPTH),
          .RETIME_STATUS(RETIME_STATUS)
        ) u_lane (
          .clk  (clk),
          .reset(reset),
          .en   (en),
          .in   (in[i][j]),
          .out  (out[i][j])
        );
      end
    end
  endgenerate

`ifdef DFF3_ASSERT_EN
  initial begin
    if (WIDTH < 1)       $fatal(1, "dff3: WIDTH must be >= 1");
    if (ARRAY_SIZE1 < 1) $fatal(1, "dff3: ARRAY_SIZE1 must be >= 1");
    if (ARRAY_SIZE2 < 1) $fatal(1, "dff3: ARRAY_SIZE2 must be >= 1");
    if (PIPE_DEPTH < 0)  $fatal(1, "dff3: PIPE_DEPTH must be >= 0");
  end

  always @(posedge clk) begin
    if (!reset && $isunknown(en)) $error("dff3: en is X/Z while out of reset");
  end
`endif

endmodule

// File: tb/tb_dff3.sv
// Directed self-checking bench for dff3: latency, stall, reset flush, depth
// comparison, zero-depth bypass and reset-free retime stages.
module tb_dff3;

  typedef logic [23:0] arr_t [2:0][2:0];

  logic clk;
  logic reset;
  logic en;
  arr_t inA;
  arr_t outA;
  arr_t outB;
  logic [0:0] inZ  [0:0][0:0];
  logic [0:0] outZ [0:0][0:0];
  logic [3:0] inR  [0:0][0:0];
  logic [3:0] outR [0:0][0:0];

  int checks = 0;
  int errors = 0;

  dff3 #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(3), .RETIME_STATUS(0)) dut (
    .clk(clk), .reset(reset), .en(en), .in(inA), .out(outA));

  dff3 #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(2), .RETIME_STATUS(0)) dutB (
    .clk(clk), .reset(reset), .en(en), .in(inA), .out(outB));

  dff3 #(.WIDTH(1), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(0), .RETIME_STATUS(0)) dutZ (
    .clk(clk), .reset(reset), .en(en), .in(inZ), .out(outZ));

  dff3 #(.WIDTH(4), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(2), .RETIME_STATUS(1)) dutR (
    .clk(clk), .reset(reset), .en(en), .in(inR), .out(outR));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane [i][j] carries base + step*(i*3+j), so every lane is distinguishable.
  function automatic arr_t mk(input logic [23:0] base, input logic [23:0] step);
    arr_t a;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        a[i][j] = base + step * 24'(i * 3 + j);
    return a;
  endfunction

  function automatic logic [215:0] flat(input arr_t a);
    logic [215:0] r;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        r[(i*3+j)*24 +: 24] = a[i][j];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [23:0] base,
                               input logic [23:0] step);
    reset = r;
    en    = e;
    inA   = mk(base, step);
  endtask

  task automatic checkOutput(input string tag, input logic [215:0] observed,
                             input logic [215:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    inZ[0][0] = 1'b0;
    inR[0][0] = 4'd0;
    applyStimulus(1'b1, 1'b1, 24'd0, 24'd0);
    tick();
    tick();
    checkOutput("reset_a", flat(outA), '0);
    checkOutput("reset_b", flat(outB), '0);

    // single pulse of 1..9 appears only on the third edge
    applyStimulus(1'b0, 1'b1, 24'd1, 24'd1);
    tick();
    inA = mk(24'd0, 24'd0);
    checkOutput("pulse_e1", flat(outA), '0);
    tick();
    checkOutput("pulse_e2", flat(outA), '0);
    tick();
    checkOutput("pulse_e3", flat(outA), flat(mk(24'd1, 24'd1)));
    tick();
    checkOutput("pulse_e4", flat(outA), '0);

    // stream with a two-cycle stall carrying a new input value
    applyStimulus(1'b0, 1'b1, 24'd16, 24'd1); tick();
    applyStimulus(1'b0, 1'b1, 24'd32, 24'd1); tick();
    applyStimulus(1'b0, 1'b1, 24'd48, 24'd1); tick();
    checkOutput("stream_p1", flat(outA), flat(mk(24'd16, 24'd1)));
    applyStimulus(1'b0, 1'b0, 24'd144, 24'd1); tick();
    checkOutput("stall_1", flat(outA), flat(mk(24'd16, 24'd1)));
    tick();
    checkOutput("stall_2", flat(outA), flat(mk(24'd16, 24'd1)));
    applyStimulus(1'b0, 1'b1, 24'd64, 24'd1); tick();
    checkOutput("resume_p2", flat(outA), flat(mk(24'd32, 24'd1)));
    applyStimulus(1'b0, 1'b1, 24'd80, 24'd1); tick();
    checkOutput("resume_p3", flat(outA), flat(mk(24'd48, 24'd1)));
    tick();
    checkOutput("resume_p4", flat(outA), flat(mk(24'd64, 24'd1)));

    // flush a pipe full of 0xABCDEF, then refill
    applyStimulus(1'b0, 1'b1, 24'hABCDEF, 24'd0);
    tick(); tick(); tick();
    checkOutput("fill_abcdef", flat(outA), flat(mk(24'hABCDEF, 24'd0)));
    applyStimulus(1'b1, 1'b1, 24'h123456, 24'd0); tick();
    checkOutput("flush_edge", flat(outA), '0);
    applyStimulus(1'b0, 1'b1, 24'h123456, 24'd0); tick();
    checkOutput("refill_e1", flat(outA), '0);
    tick();
    checkOutput("refill_e2", flat(outA), '0);
    tick();
    checkOutput("refill_e3", flat(outA), flat(mk(24'h123456, 24'd0)));
    applyStimulus(1'b1, 1'b0, 24'h123456, 24'd0); tick();
    checkOutput("reset_over_en0", flat(outA), '0);

    // depth 3 vs depth 2 on a changing input, then a held input
    applyStimulus(1'b1, 1'b1, 24'd0, 24'd0); tick();
    applyStimulus(1'b0, 1'b1, 24'd160, 24'd1); tick();
    checkOutput("cmp1_a", flat(outA), '0);
    checkOutput("cmp1_b", flat(outB), '0);
    applyStimulus(1'b0, 1'b1, 24'd176, 24'd1); tick();
    checkOutput("cmp2_a", flat(outA), '0);
    checkOutput("cmp2_b", flat(outB), flat(mk(24'd160, 24'd1)));
    applyStimulus(1'b0, 1'b1, 24'd192, 24'd1); tick();
    checkOutput("cmp3_a", flat(outA), flat(mk(24'd160, 24'd1)));
    checkOutput("cmp3_b", flat(outB), flat(mk(24'd176, 24'd1)));
    applyStimulus(1'b0, 1'b1, 24'd208, 24'd1); tick();
    checkOutput("cmp4_a", flat(outA), flat(mk(24'd176, 24'd1)));
    checkOutput("cmp4_b", flat(outB), flat(mk(24'd192, 24'd1)));
    applyStimulus(1'b0, 1'b1, 24'd320, 24'd1); tick();
    checkOutput("cmp5_a", flat(outA), flat(mk(24'd192, 24'd1)));
    checkOutput("cmp5_b", flat(outB), flat(mk(24'd208, 24'd1)));
    checks++;
    assert (flat(outA) !== flat(outB))
    else begin
      errors++;
      $error("[TB] FAIL cmp5_differ observed=%h expected=not %h", flat(outA), flat(outB));
    end
    tick();
    checkOutput("cmp6_a", flat(outA), flat(mk(24'd208, 24'd1)));
    checkOutput("cmp6_b", flat(outB), flat(mk(24'd320, 24'd1)));
    tick();
    checkOutput("cmp7_a", flat(outA), flat(mk(24'd320, 24'd1)));
    checkOutput("cmp7_b", flat(outB), flat(mk(24'd320, 24'd1)));

    // zero-depth instance is a wire regardless of clk/reset/en
    reset = 1'b1;
    en    = 1'b0;
    inZ[0][0] = 1'b1;
    #1;
    checkOutput("bypass_1", 216'(outZ[0][0]), 216'd1);
    inZ[0][0] = 1'b0;
    #1;
    checkOutput("bypass_0", 216'(outZ[0][0]), 216'd0);
    @(posedge clk);
    inZ[0][0] = 1'b1;
    #1;
    checkOutput("bypass_edge", 216'(outZ[0][0]), 216'd1);

    // retime instance ignores reset entirely
    reset = 1'b1;
    en    = 1'b1;
    inR[0][0] = 4'd5;
    tick();
    tick();
    checkOutput("retime_5", 216'(outR[0][0]), 216'd5);
    inR[0][0] = 4'd9;
    tick();
    checkOutput("retime_hold5", 216'(outR[0][0]), 216'd5);
    tick();
    checkOutput("retime_9", 216'(outR[0][0]), 216'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff3.md
DFF3 -- requirements
Module: dff3

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each array element; SHALL be >= 1.
REQ-002 Parameter ARRAY_SIZE1, default 1, outer array dimension; SHALL be >= 1.
REQ-003 Parameter ARRAY_SIZE2, default 1, inner array dimension; SHALL be >= 1.
REQ-004 Parameter PIPE_DEPTH, default 1, number of register stages; SHALL be >= 0.
REQ-005 Parameter RETIME_STATUS, default 0, 0 = reset stages, 1 = retimeable stages with no reset.
REQ-006 Design has one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  rising-edge clock for all stages.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 en  input  1  stage enable; high advances the pipe one stage per clock.
REQ-010 in  input  [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0] x WIDTH (unpacked array of logic [WIDTH-1:0])  data in.
REQ-011 out  output  same shape and type as in  data delayed by PIPE_DEPTH enabled clocks.

Function
REQ-012 PIPE_DEPTH = 0: out SHALL equal in combinationally; clk, reset and en are ignored and no flops are inferred.
REQ-013 PIPE_DEPTH = N >= 1: the module SHALL hold N stages per element; out[i][j] SHALL be the value of in[i][j] captured N enabled rising edges earlier.
REQ-014 en = 1 at a rising edge: stage 0 SHALL load in, and stage k SHALL load stage k-1 for k = 1..N-1.
REQ-015 en = 0 at a rising edge: all stages SHALL hold, and out SHALL be stable.
REQ-016 Every element [i][j] SHALL be an independent lane with identical timing; there is no cross-lane interaction.
REQ-017 Data SHALL pass bit-exact; signedness is not interpreted.
REQ-018 out SHALL be driven directly from the last stage, with no output logic after the final flop.

Reset
REQ-019 RETIME_STATUS = 0: reset = 1 at a rising edge SHALL clear every stage to zero, so out = 0 from the next edge.
REQ-020 RETIME_STATUS = 0: reset SHALL take priority over en, including when en = 0.
REQ-021 RETIME_STATUS = 0: reset asserted mid-stream SHALL discard all in-flight data; valid output resumes N enabled edges after reset deasserts.
REQ-022 RETIME_STATUS = 1: stages SHALL have no reset, reset SHALL be ignored, and stage contents are X until filled by N enabled edges.
REQ-023 PIPE_DEPTH = 0: reset SHALL have no effect.

Configuration
REQ-024 Macro DFF3_ASSERT_EN defined: simulation-only elaboration checks SHALL be compiled in; each check SHALL report $fatal when WIDTH < 1, either ARRAY_SIZE < 1, or PIPE_DEPTH < 0.
REQ-025 Macro DFF3_ASSERT_EN defined: a clocked check SHALL flag $error when en is X/Z while reset = 0.
REQ-026 Macro DFF3_ASSERT_EN undefined: none of the checks SHALL be present, and RTL behaviour SHALL be identical either way.

Structure
REQ-027 Shared package dff_pkg SHALL hold the default parameter constants and the RETIME_STATUS encoding (RETIME_OFF = 0, RETIME_ON = 1).
REQ-028 Sub-module dff (parameters WIDTH, PIPE_DEPTH, RETIME_STATUS; ports clk, reset, en, in[WIDTH-1:0], out[WIDTH-1:0]) SHALL implement one lane.
REQ-029 dff SHALL follow the same rules as dff3 and SHALL be usable standalone.
REQ-030 dff3 SHALL instantiate ARRAY_SIZE1 x ARRAY_SIZE2 dff lanes via nested generate loops.

Verification
REQ-031 WIDTH=24, 3x3, PIPE_DEPTH=3, RETIME_STATUS=0, en=1, in[i][j]=i*3+j+1 for one cycle then 0 -> out shows 1..9 on exactly the 3rd edge after capture, and 0 otherwise.
REQ-032 Same configuration, en=0 for 2 cycles mid-stream with a new in value -> out holds its last value for 2 cycles, then the sequence continues with no loss or duplication.
REQ-033 Same configuration, reset=1 for 1 cycle while the pipe holds 0xABCDEF -> out = 0 on the next edge, and 0x000000 persists until new data propagates 3 edges.
REQ-034 Two instances fed the same in, PIPE_DEPTH=3 and PIPE_DEPTH=2, in changes every cycle -> the outputs differ every cycle and are equal only when in is held constant for >= 3 cycles.
REQ-035 PIPE_DEPTH=0, WIDTH=1 -> out tracks in within the same timestep regardless of clk, reset and en.
REQ-036 RETIME_STATUS=1, PIPE_DEPTH=2, reset=1 with en=1 and in=5 -> out = 5 after 2 edges, i.e. reset is ignored.
